local_mem_banked: RTL
=====================

// Module: local_mem_banked
// PURPOSE
//  Multi-line local scratch memory for the Matrix Processing Unit: DEPTH lines of CHUNK_BITS each.
//  Compute side reads/writes whole lines; host side reads/writes one HOST_BITS lane at a time.
//  Built-in streamer drains one line to the host lane-by-lane over a valid/ready handshake.
//  Successor to the single-line bram: multi-line, parametrised lane width, registered reads, streaming.
// PARAMETERS
//  CHUNK_BITS  512  line width in bits; must be a multiple of HOST_BITS (elaboration error otherwise)
//  HOST_BITS   8    host lane width in bits
//  DEPTH       4    number of lines; >=2
//  (local) ADDR_W = $clog2(DEPTH), LANES = CHUNK_BITS/HOST_BITS, LANE_W = $clog2(LANES)
// PORTS
//  clk             in   1           single clock, rising edge
//  rst             in   1           reset: asynchronous, active-high
//  chunk_wr_en     in   1           write chunk_in to line chunk_addr
//  chunk_rd_en     in   1           read line chunk_addr
//  chunk_addr      in   ADDR_W      line select, compute side
//  chunk_in        in   CHUNK_BITS  write data, compute side
//  chunk_out       out  CHUNK_BITS  registered read data
//  chunk_out_valid out  1           pulse: chunk_out updated this cycle
//  host_wr_en      in   1           write host_in to lane host_lane of line host_addr
//  host_rd_en      in   1           read lane host_lane of line host_addr
//  host_addr       in   ADDR_W      line select, host side
//  host_lane       in   LANE_W      lane i = bits [i*HOST_BITS +: HOST_BITS]
//  host_in         in   HOST_BITS   host write data
//  host_out        out  HOST_BITS   registered host read data
//  host_out_valid  out  1           pulse: host_out updated this cycle
//  strm_start      in   1           start draining line strm_addr (ignored while strm_busy)
//  strm_addr       in   ADDR_W      line to stream
//  strm_data       out  HOST_BITS   current stream beat
//  strm_valid      out  1           beat valid
//  strm_ready      in   1           consumer accepts beat when valid&ready
//  strm_last       out  1           high with final beat (lane LANES-1)
//  strm_busy       out  1           streamer not IDLE
// BEHAVIOUR
//  - Reset: every line, chunk_out, host_out, strm_data = 0; all valid/last/busy = 0; streamer IDLE.
//  - Writes land at the clock edge where the enable is sampled. Reads: 1-cycle latency, output held until next read.
//  - Read-during-write, same line same cycle: read returns OLD data.
//  - chunk_wr_en and host_wr_en to the same line same cycle: chunk write wins, host lane write dropped.
//    Different lines: both take effect.
//  - Address >= DEPTH (non-power-of-2 DEPTH): writes ignored, reads return 0 with valid still pulsed.
//  - Streamer FSM, states IDLE, SEND:
//    IDLE: strm_start -> snapshot line strm_addr into shadow reg, lane_cnt=0, go SEND. Start same cycle
//      as a write to that line snapshots OLD data. Later writes never affect an in-flight stream.
//    SEND: strm_valid=1, strm_data=shadow lane lane_cnt, strm_last=(lane_cnt==LANES-1).
//      valid&ready: lane_cnt++; on last beat go IDLE (strm_valid low next cycle).
//      Data held stable while valid&!ready. Exactly LANES beats, lane 0 first; no drop, no duplicate.
//    strm_busy = (state!=IDLE); strm_start while busy is ignored, not queued.
//  - Host/chunk ports remain fully operational while streaming.
//  - rst mid-operation: immediate async return to reset state; partial stream abandoned, no strm_last.
// STRUCTURE
//  - Package local_mem_pkg: default CHUNK_BITS/HOST_BITS/DEPTH constants, streamer state enum.
//  - Sub-module chunk_streamer: shadow register, lane counter, IDLE/SEND FSM, handshake outputs.
//  - Top: line storage array (flops, async clear), write arbitration, registered read muxes.
// TESTING (CHUNK_BITS=512, HOST_BITS=8, DEPTH=4)
//  1 Reset, chunk_rd_en lines 0..3 -> chunk_out==0, chunk_out_valid one cycle after each rd_en.
//  2 chunk write {256{2'b01}} line1, {256{2'b10}} line2; read back exact; line0 still 0.
//  3 host write line3 lane i = i (i=0..63); host reads return i; chunk read line3 byte i == i.
//  4 Stream line3, strm_ready toggling every cycle -> beats 0x00..0x3F in order, strm_last only on 0x3F;
//    chunk write 0xFF.. to line3 at beat 5 leaves remaining beats unchanged.
//  5 Same cycle chunk_wr line1=0 and host_wr line1 lane0=0xAB -> lane0 reads 0x00; same-cycle read returns old line.
//  6 rst pulse at beat 10 of a stream -> strm_valid/strm_busy low immediately, all lines read 0, new start works.

Source files
------------

// File: rtl/local_mem_pkg.sv
// Shared defaults and streamer state encoding for the banked local memory.
package local_mem_pkg;
    localparam int DEF_CHUNK_BITS = 512;
    localparam int DEF_HOST_BITS  = 8;
    localparam int DEF_DEPTH      = 4;

    // Streamer state: plain constants so older code can compare against them.
    typedef logic [0:0] strm_state_t;
    localparam strm_state_t ST_IDLE = 1'b0;
    localparam strm_state_t ST_SEND = 1'b1;
endpackage

// File: rtl/chunk_streamer.sv
// Drains one snapshotted line to the host lane-by-lane over valid/ready.
module chunk_streamer
    import local_mem_pkg::*;
#(
    parameter int CHUNK_BITS = DEF_CHUNK_BITS,
    parameter int HOST_BITS  = DEF_HOST_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CHUNK_BITS-1:0] line,
    input  logic                  ready,
    output logic [HOST_BITS-1:0]  data,
    output logic                  valid,
    output logic                  last,
    output logic                  busy
);
    localparam int LANES  = CHUNK_BITS / HOST_BITS;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    strm_state_t           state;
    logic [CHUNK_BITS-1:0] shadow;
    logic [LANE_W-1:0]     lane_cnt;
    logic                  last_lane;

    assign last_lane = (lane_cnt == LANE_W'(LANES - 1));
    assign busy      = (state == ST_SEND);
    assign valid     = busy;
    assign last      = busy && last_lane;
    // The shadow shifts down on each accepted beat, so lane 0 of it is always the current beat.
    assign data      = busy ? shadow[HOST_BITS-1:0] : '0;

    // IDLE/SEND FSM: snapshot on start, advance one lane per handshake, stop after last lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            lane_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                shadow   <= line;
                lane_cnt <= '0;
                state    <= ST_SEND;
            end
        end else if (ready) begin
            shadow   <= shadow >> HOST_BITS;
            lane_cnt <= lane_cnt + LANE_W'(1);
            if (last_lane)
                state <= ST_IDLE;
        end
    end
endmodule

// File: rtl/local_mem_banked.sv
// Multi-line scratch memory: whole-line compute port, lane-wide host port, line streamer.
module local_mem_banked
    import local_mem_pkg::*;
#(
    parameter int CHUNK_BITS = DEF_CHUNK_BITS,
    parameter int HOST_BITS  = DEF_HOST_BITS,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LANES     = CHUNK_BITS / HOST_BITS,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chunk_wr_en,
    input  logic                  chunk_rd_en,
    input  logic [ADDR_W-1:0]     chunk_addr,
    input  logic [CHUNK_BITS-1:0] chunk_in,
    output logic [CHUNK_BITS-1:0] chunk_out,
    output logic                  chunk_out_valid,
    input  logic                  host_wr_en,
    input  logic                  host_rd_en,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [LANE_W-1:0]     host_lane,
    input  logic [HOST_BITS-1:0]  host_in,
    output logic [HOST_BITS-1:0]  host_out,
    output logic                  host_out_valid,
    input  logic                  strm_start,
    input  logic [ADDR_W-1:0]     strm_addr,
    output logic [HOST_BITS-1:0]  strm_data,
    output logic                  strm_valid,
    input  logic                  strm_ready,
    output logic                  strm_last,
    output logic                  strm_busy
);
    if (CHUNK_BITS % HOST_BITS != 0) begin : g_bad_width
        $error("local_mem_banked: CHUNK_BITS must be a multiple of HOST_BITS");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("local_mem_banked: DEPTH must be at least 2");
    end

    logic [DEPTH-1:0][CHUNK_BITS-1:0] mem;
    logic [CHUNK_BITS-1:0]            chunk_line, host_line, strm_line;

    // Read muxes by equality match: an address past DEPTH matches no line and yields zero.
    always_comb begin
        chunk_line = '0;
        host_line  = '0;
        strm_line  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (chunk_addr == ADDR_W'(i)) chunk_line = mem[i];
            if (host_addr  == ADDR_W'(i)) host_line  = mem[i];
            if (strm_addr  == ADDR_W'(i)) strm_line  = mem[i];
        end
    end

    // Line storage; a chunk write to a line shadows a host lane write to the same line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (chunk_wr_en && chunk_addr == ADDR_W'(i))
                    mem[i] <= chunk_in;
                else if (host_wr_en && host_addr == ADDR_W'(i))
                    mem[i][int'(host_lane) * HOST_BITS +: HOST_BITS] <= host_in;
            end
        end
    end

    // Registered reads sample pre-write contents, so read-during-write returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_out       <= '0;
            chunk_out_valid <= 1'b0;
            host_out        <= '0;
            host_out_valid  <= 1'b0;
        end else begin
            chunk_out_valid <= chunk_rd_en;
            host_out_valid  <= host_rd_en;
            if (chunk_rd_en) chunk_out <= chunk_line;
            if (host_rd_en)  host_out  <= host_line[int'(host_lane) * HOST_BITS +: HOST_BITS];
        end
    end

    chunk_streamer #(
        .CHUNK_BITS (CHUNK_BITS),
        .HOST_BITS  (HOST_BITS)
    ) u_streamer (
        .clk   (clk),
        .rst   (rst),
        .start (strm_start),
        .line  (strm_line),
        .ready (strm_ready),
        .data  (strm_data),
        .valid (strm_valid),
        .last  (strm_last),
        .busy  (strm_busy)
    );
endmodule
